// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - DES tables, S-box functions, decrypt rotate schedule and FSM state type
// Bit numbering is MSB-first [1:n] throughout; every table entry names a 1-based source bit.
package des_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

    // Parity bits 8,16,...,64 never appear here, so they cannot influence the result.
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

    // Right-rotate amount applied to C/D before round r, stored at index r-1.
    // Indexing with the low 4 bits of the current round number gives the
    // amount for the next round (round 16 wraps to entry 0, which is unused).
    localparam logic [1:0] ROT_DEC [16] = '{
        2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

    // Each box is row-major: entry = row*16 + column.
    localparam logic [3:0] SBOX [8][64] = '{
        '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
           4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
        '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
           0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
        '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
          13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
        '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
          10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
        '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
           4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
        '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
           9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
        '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
           1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
        '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
           7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

    function automatic logic [1:64] ip_perm(input logic [1:64] x);
        logic [1:64] y;
        for (int i = 0; i < 64; i++) y[i+1] = x[IP_T[i]];
        return y;
    endfunction

    function automatic logic [1:64] fp_perm(input logic [1:64] x);
        logic [1:64] y;
        for (int i = 0; i < 64; i++) y[i+1] = x[FP_T[i]];
        return y;
    endfunction

    function automatic logic [1:56] pc1_perm(input logic [1:64] x);
        logic [1:56] y;
        for (int i = 0; i < 56; i++) y[i+1] = x[PC1_T[i]];
        return y;
    endfunction

    function automatic logic [1:48] pc2_perm(input logic [1:56] x);
        logic [1:48] y;
        for (int i = 0; i < 48; i++) y[i+1] = x[PC2_T[i]];
        return y;
    endfunction

    function automatic logic [1:48] e_expand(input logic [1:32] x);
        logic [1:48] y;
        for (int i = 0; i < 48; i++) y[i+1] = x[E_T[i]];
        return y;
    endfunction

    function automatic logic [1:32] p_perm(input logic [1:32] x);
        logic [1:32] y;
        for (int i = 0; i < 32; i++) y[i+1] = x[P_T[i]];
        return y;
    endfunction

    // Row comes from outer bits 1 and 6, column from inner bits 2..5.
    function automatic logic [1:4] s_lookup(input int n, input logic [1:6] x);
        logic [5:0] idx;
        idx = {x[1], x[6], x[2:5]};
        return SBOX[n][idx];
    endfunction

    function automatic logic [1:4] s1(input logic [1:6] x); return s_lookup(0, x); endfunction
    function automatic logic [1:4] s2(input logic [1:6] x); return s_lookup(1, x); endfunction
    function automatic logic [1:4] s3(input logic [1:6] x); return s_lookup(2, x); endfunction
    function automatic logic [1:4] s4(input logic [1:6] x); return s_lookup(3, x); endfunction
    function automatic logic [1:4] s5(input logic [1:6] x); return s_lookup(4, x); endfunction
    function automatic logic [1:4] s6(input logic [1:6] x); return s_lookup(5, x); endfunction
    function automatic logic [1:4] s7(input logic [1:6] x); return s_lookup(6, x); endfunction
    function automatic logic [1:4] s8(input logic [1:6] x); return s_lookup(7, x); endfunction

    function automatic logic [1:28] rot_right(input logic [1:28] x, input logic [1:0] amt);
        case (amt)
            2'd1:    return {x[28], x[1:27]};
            2'd2:    return {x[27:28], x[1:26]};
            default: return x;
        endcase
    endfunction

endpackage

// File: rtl/des_decrypt_core_if.sv
// rtl/des_decrypt_core_if.sv - ciphertext/key input and plaintext output handshake bundle
// master: block source/sink (drives in_valid, ciphertext, key, out_ready)
// slave:  decrypt core (drives in_ready, out_valid, plaintext, busy)
interface des_decrypt_core_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:64] ciphertext;
    logic [1:64] key;
    logic        out_valid;
    logic        out_ready;
    logic [1:64] plaintext;
    logic        busy;

    modport master (
        output in_valid, ciphertext, key, out_ready,
        input  in_ready, out_valid, plaintext, busy
    );

    modport slave (
        input  in_valid, ciphertext, key, out_ready,
        output in_ready, out_valid, plaintext, busy
    );
endinterface

// File: rtl/des_round_comb.sv
// rtl/des_round_comb.sv - combinational DES round function f(R, K)
// Ports: r [1:32] right half in, k [1:48] round subkey in, f [1:32] function result out.
module des_round_comb
    import des_pkg::*;
(
    input  logic [1:32] r,
    input  logic [1:48] k,
    output logic [1:32] f
);
    logic [1:48] x;
    logic [1:32] s_out;

    always_comb begin
        x = e_expand(r) ^ k;
        s_out = {s1(x[1:6]),   s2(x[7:12]),  s3(x[13:18]), s4(x[19:24]),
                 s5(x[25:30]), s6(x[31:36]), s7(x[37:42]), s8(x[43:48])};
        f = p_perm(s_out);
    end
endmodule

// File: rtl/des_decrypt_core.sv
// rtl/des_decrypt_core.sv - iterative 16-round DES decryption engine, one round per clock
// Ports: clk, rst (sync active-high), bus (slave side: in_valid/in_ready/ciphertext/key in,
// out_valid/out_ready/plaintext out, busy while a block is in flight).
module des_decrypt_core
    import des_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    des_decrypt_core_if.slave  bus
);
    state_t      state;
    logic [1:32] l_q, r_q;
    logic [1:28] c_q, d_q;
    logic [4:0]  rnd;
    logic [1:64] plaintext_q;
    logic        out_valid_q;
    logic        in_ready_q;
    logic [1:48] subkey;
    logic [1:32] f_out;
    logic [1:56] cd_init;
    logic [1:32] r_new;

    // C/D always hold the halves for the round about to run, so the subkey
    // is a pure PC2 of the current registers (K16 first, K1 last).
    assign subkey  = pc2_perm({c_q, d_q});
    assign cd_init = pc1_perm(bus.key);
    assign r_new   = l_q ^ f_out;

    des_round_comb u_round (
        .r (r_q),
        .k (subkey),
        .f (f_out)
    );

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.plaintext = plaintext_q;
    assign bus.busy      = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            l_q         <= '0;
            r_q         <= '0;
            c_q         <= '0;
            d_q         <= '0;
            rnd         <= '0;
            plaintext_q <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        {l_q, r_q} <= ip_perm(bus.ciphertext);
                        c_q        <= cd_init[1:28];
                        d_q        <= cd_init[29:56];
                        rnd        <= 5'd1;
                        in_ready_q <= 1'b0;
                        state      <= ST_ROUND;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                ST_ROUND: begin
                    l_q <= r_q;
                    r_q <= r_new;
                    c_q <= rot_right(c_q, ROT_DEC[rnd[3:0]]);
                    d_q <= rot_right(d_q, ROT_DEC[rnd[3:0]]);
                    rnd <= rnd + 5'd1;
                    if (rnd == 5'd16) begin
                        // Halves swap on the way out: preoutput is {R16, L16}.
                        plaintext_q <= fp_perm({r_new, r_q});
                        out_valid_q <= 1'b1;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_des_decrypt_core.sv
// tb/tb_des_decrypt_core.sv - directed-vector bench for des_decrypt_core
module tb_des_decrypt_core;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    des_decrypt_core_if bus ();

    des_decrypt_core dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    localparam logic [1:64] K1  = 64'h133457799BBCDFF1;
    localparam logic [1:64] C1  = 64'h85E813540F0AB405;
    localparam logic [1:64] P1  = 64'h0123456789ABCDEF;
    localparam logic [1:64] K2  = 64'h0000000000000000;
    localparam logic [1:64] K2P = 64'h0101010101010101;
    localparam logic [1:64] C2  = 64'h8CA64DE9C1B123A7;
    localparam logic [1:64] P2  = 64'h0000000000000000;
    localparam logic [1:64] K3  = 64'h0E329232EA6D0D73;
    localparam logic [1:64] C3  = 64'h0000000000000000;
    localparam logic [1:64] P3  = 64'h8787878787878787;

    // Present one block at a negedge where in_ready is high; returns after the
    // accept edge (at the following negedge) with in_valid dropped.
    task automatic send(input logic [1:64] ct, input logic [1:64] k);
        int n;
        n = 0;
        while (!bus.in_ready && n < 40) begin @(negedge clk); n++; end
        bus.in_valid   = 1'b1;
        bus.ciphertext = ct;
        bus.key        = k;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Cycles (negedges) from just after the accept edge until out_valid.
    task automatic wait_out(output int n);
        n = 0;
        while (!bus.out_valid && n < 40) begin @(negedge clk); n++; end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.ciphertext = '0; bus.key = '0;
        repeat (2) @(negedge clk);
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        total++; if (bus.plaintext !== 64'h0) begin bad++; $display("FAIL reset_plaintext got=%h want=0", bus.plaintext); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%b want=1", bus.in_ready); end
    endtask

    task automatic test_vector1();
        int n;
        send(C1, K1);
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL v1_busy got=%b want=1", bus.busy); end
        wait_out(n);
        total++; if (n != 16) begin bad++; $display("FAIL v1_latency got=%0d want=16", n); end
        total++; if (bus.plaintext !== P1) begin bad++; $display("FAIL v1_plaintext got=%h want=%h", bus.plaintext, P1); end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL v1_out_drop got=%b want=0", bus.out_valid); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL v1_in_ready_after got=%b want=1", bus.in_ready); end
    endtask

    task automatic test_zero_and_parity_key();
        int n;
        send(C2, K2);
        wait_out(n);
        total++; if (bus.plaintext !== P2 || n != 16) begin bad++; $display("FAIL zero_key got=%h lat=%0d want=%h lat=16", bus.plaintext, n, P2); end
        bus.out_ready = 1'b1; @(negedge clk); bus.out_ready = 1'b0;
        send(C2, K2P);
        wait_out(n);
        total++; if (bus.plaintext !== P2 || n != 16) begin bad++; $display("FAIL parity_key got=%h lat=%0d want=%h lat=16", bus.plaintext, n, P2); end
        bus.out_ready = 1'b1; @(negedge clk); bus.out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int n;
        send(C3, K3);
        wait_out(n);
        total++; if (bus.plaintext !== P3) begin bad++; $display("FAIL bp_plaintext got=%h want=%h", bus.plaintext, P3); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if (bus.out_valid !== 1'b1 || bus.plaintext !== P3 || bus.in_ready !== 1'b0) begin
                bad++; $display("FAIL bp_hold cyc=%0d got ov=%b pt=%h ir=%b want ov=1 pt=%h ir=0",
                                i, bus.out_valid, bus.plaintext, bus.in_ready, P3);
            end
        end
        bus.out_ready = 1'b1; @(negedge clk); bus.out_ready = 1'b0;
        total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got ov=%b ir=%b want ov=0 ir=1", bus.out_valid, bus.in_ready); end
    endtask

    task automatic test_ignore_changes();
        int n;
        send(C2, K2);
        // Offer a different block while rounds are running; it must not leak in.
        bus.in_valid = 1'b1; bus.ciphertext = C1; bus.key = K1;
        repeat (8) begin
            total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL ign_in_ready got=%b want=0", bus.in_ready); end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        wait_out(n);
        total++; if (bus.plaintext !== P2 || n != 8) begin bad++; $display("FAIL ign_result got=%h wait=%0d want=%h wait=8", bus.plaintext, n, P2); end
        bus.out_ready = 1'b1; @(negedge clk); bus.out_ready = 1'b0;
    endtask

    task automatic test_mid_reset();
        int n;
        send(C1, K1);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++; if (bus.out_valid !== 1'b0 || bus.plaintext !== 64'h0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL midrst_state got ov=%b pt=%h busy=%b want 0/0/0", bus.out_valid, bus.plaintext, bus.busy); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready got=%b want=1", bus.in_ready); end
        repeat (20) @(negedge clk);
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_no_output got=%b want=0", bus.out_valid); end
        send(C3, K3);
        wait_out(n);
        total++; if (bus.plaintext !== P3 || n != 16) begin bad++; $display("FAIL midrst_next got=%h lat=%0d want=%h lat=16", bus.plaintext, n, P3); end
        bus.out_ready = 1'b1; @(negedge clk); bus.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [1:64] cts [3];
        logic [1:64] keys [3];
        logic [1:64] exps [3];
        int rise [3];
        int sent, got;
        logic pending, prev_ov;
        cts  = '{C1, C2, C3};
        keys = '{K1, K2, K3};
        exps = '{P1, P2, P3};
        sent = 0; got = 0; pending = 1'b0; prev_ov = 1'b0;
        while (!bus.in_ready) @(negedge clk);
        bus.in_valid = 1'b1; bus.ciphertext = cts[0]; bus.key = keys[0];
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 120 && got < 3; cyc++) begin
            if (pending) begin
                sent++;
                if (sent < 3) begin bus.ciphertext = cts[sent]; bus.key = keys[sent]; end
                else bus.in_valid = 1'b0;
            end
            pending = bus.in_ready && bus.in_valid;
            if (bus.out_valid && !prev_ov) begin
                rise[got] = cyc;
                total++; if (bus.plaintext !== exps[got]) begin bad++; $display("FAIL b2b_plaintext idx=%0d got=%h want=%h", got, bus.plaintext, exps[got]); end
                got++;
            end
            prev_ov = bus.out_valid;
            @(negedge clk);
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        total++; if (got != 3) begin bad++; $display("FAIL b2b_count got=%0d want=3", got); end
        if (got == 3) begin
            total++; if (rise[1] - rise[0] != 18) begin bad++; $display("FAIL b2b_spacing01 got=%0d want=18", rise[1] - rise[0]); end
            total++; if (rise[2] - rise[1] != 18) begin bad++; $display("FAIL b2b_spacing12 got=%0d want=18", rise[2] - rise[1]); end
        end
    endtask

    initial begin
        test_reset();
        test_vector1();
        test_zero_and_parity_key();
        test_backpressure();
        test_ignore_changes();
        test_mid_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
